freq_bcd_counter: RTL and testbench

- Upstream feeder for the four-digit seven-segment display controller.
- Counts rising edges of the asynchronous external signal IN over a fixed gate window of GATE_CYCLES clocks, which is 1 s at 100 MHz.
- Counts directly in packed 4-digit BCD and latches the result at each window end. The display controller consumes freq continuously without conversion.
- Saturates at 9999 and flags overflow.

---
 rtl/freq_bcd_counter.sv | 64 ++++++
 tb/tb_freq_bcd_counter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_bcd_counter.sv
// freq_bcd_counter: counts rising edges of asynchronous IN over a fixed gate window
// and publishes the count as saturating packed 4-digit BCD with an overflow flag.
module freq_bcd_counter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int GATE_W      = 27
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        IN,
    output logic [15:0] freq,
    output logic        valid,
    output logic        overflow
);
    logic              s1, s2, s3;
    logic [GATE_W-1:0] gate;
    logic [15:0]       acc, acc_inc, acc_nxt;
    logic [3:0]        carry;
    logic              ovf_acc, ovf_nxt, in_edge, term, sat;

    assign in_edge = s2 & ~s3;
    assign term    = gate == GATE_W'(GATE_CYCLES - 1);
    assign sat     = acc == 16'h9999;

    // Decimal ripple increment: every digit sitting at 9 wraps and passes the carry upward.
    assign carry[0] = 1'b1;
    for (genvar d = 0; d < 4; d++) begin : g_dig
        logic [3:0] dg;
        assign dg = acc[4*d +: 4];
        assign acc_inc[4*d +: 4] = carry[d] ? (dg == 4'd9 ? 4'd0 : dg + 4'd1) : dg;
        if (d < 3) begin : g_c
            assign carry[d+1] = carry[d] & (dg == 4'd9);
        end
    end

    assign acc_nxt = (in_edge && !sat) ? acc_inc : acc;
    assign ovf_nxt = ovf_acc | (in_edge & sat);

    // The terminal cycle publishes the post-increment value, so an edge there stays in the closing window.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            gate     <= '0;
            acc      <= '0;
            ovf_acc  <= 1'b0;
            freq     <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            s1      <= IN;
            s2      <= s1;
            s3      <= s2;
            gate    <= term ? '0 : gate + GATE_W'(1);
            acc     <= term ? '0 : acc_nxt;
            ovf_acc <= term ? 1'b0 : ovf_nxt;
            valid   <= term;
            if (term) begin
                freq     <= acc_nxt;
                overflow <= ovf_nxt;
            end
        end
    end
endmodule

// File: tb/tb_freq_bcd_counter.sv
// tb_freq_bcd_counter: scoreboarded bench over three gate lengths (100, 5000, 25000).
module tb_freq_bcd_counter;
    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  in_v = '0;
    logic [15:0] f [3];
    logic [2:0]  v, o;
    int          errors = 0, checks = 0, cyc = 0, rel = 0, last = 0, bad = 0, first = 0;
    bit          ok;
    logic [16:0] e;
    logic [16:0] exp_q [$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    freq_bcd_counter #(.GATE_CYCLES(100), .GATE_W(7)) u_a (
        .CLK(CLK), .reset(reset), .IN(in_v[0]), .freq(f[0]), .valid(v[0]), .overflow(o[0]));
    freq_bcd_counter #(.GATE_CYCLES(5000), .GATE_W(13)) u_b (
        .CLK(CLK), .reset(reset), .IN(in_v[1]), .freq(f[1]), .valid(v[1]), .overflow(o[1]));
    freq_bcd_counter #(.GATE_CYCLES(25000), .GATE_W(15)) u_c (
        .CLK(CLK), .reset(reset), .IN(in_v[2]), .freq(f[2]), .valid(v[2]), .overflow(o[2]));

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Window posedge k after release is the one where cyc becomes rel+k.
    task automatic do_reset;
        in_v  = '0;
        reset = 1'b0;
        repeat (3) tick;
        reset = 1'b1;
        rel   = cyc;
        exp_q.delete();
    endtask

    task automatic at(input int k);
        while (cyc < rel + k) tick;
    endtask

    task automatic pulses(input int idx, input int n, input int half);
        repeat (n) begin
            in_v[idx] = 1'b1;
            repeat (half) tick;
            in_v[idx] = 1'b0;
            repeat (half) tick;
        end
    endtask

    task automatic wait_valid(input int idx, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick;
            hit = v[idx];
        end
    endtask

    function automatic bit has_af(input logic [15:0] x);
        for (int i = 0; i < 4; i++) if (x[i*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset;
        do_reset;
        checks++;
        if ({f[0], v[0], o[0]} !== 18'h0) begin
            errors++;
            $display("FAIL reset_state: got freq=%h valid=%0b ovf=%0b, want 0000/0/0", f[0], v[0], o[0]);
        end
        bad = 0;
        for (int k = 1; k < 100; k++) begin
            tick;
            if (v[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_early_valid: got %0d valid cycles, want 0", bad);
        end
        tick;
        checks++;
        if (v[0] !== 1'b1 || f[0] !== 16'h0000 || o[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_window: got valid=%0b freq=%h ovf=%0b, want 1/0000/0", v[0], f[0], o[0]);
        end
    endtask

    task automatic test_period10;
        do_reset;
        repeat (3) exp_q.push_back({1'b0, 16'h0010});
        fork
            pulses(0, 30, 5);
            for (int w = 0; w < 3; w++) begin
                wait_valid(0, 105, ok);
                e = exp_q.pop_front();
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL period10_timeout w%0d: no valid in 105 cycles", w);
                end else if ({o[0], f[0]} !== e) begin
                    errors++;
                    $display("FAIL period10 w%0d: got ovf=%0b freq=%h, want ovf=%0b freq=%h", w, o[0], f[0], e[16], e[15:0]);
                end
                if (w > 0) begin
                    checks++;
                    if (cyc - last !== 100) begin
                        errors++;
                        $display("FAIL period10_interval w%0d: got %0d, want 100", w, cyc - last);
                    end
                end
                last = cyc;
            end
        join
    endtask

    task automatic test_reset_mid;
        do_reset;
        pulses(0, 10, 5);
        checks++;
        if (v[0] !== 1'b1 || f[0] !== 16'h0010) begin
            errors++;
            $display("FAIL mid_pre_window: got valid=%0b freq=%h, want 1/0010", v[0], f[0]);
        end
        pulses(0, 7, 5);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({f[0], v[0], o[0]} !== 18'h0) begin
            errors++;
            $display("FAIL mid_async_clear: got freq=%h valid=%0b ovf=%0b, want 0000/0/0", f[0], v[0], o[0]);
        end
        tick;
        reset = 1'b1;
        rel   = cyc;
        first = 0;
        for (int k = 1; k <= 110 && first == 0; k++) begin
            tick;
            if (v[0]) first = k;
        end
        checks++;
        if (first !== 100 || f[0] !== 16'h0000) begin
            errors++;
            $display("FAIL mid_restart: got valid at %0d freq=%h, want valid at 100 freq=0000", first, f[0]);
        end
    endtask

    task automatic test_hold;
        do_reset;
        exp_q.push_back(17'h0_0000);
        exp_q.push_back(17'h0_0000);
        exp_q.push_back(17'h0_0001);
        exp_q.push_back(17'h0_0000);
        exp_q.push_back(17'h0_0000);
        fork
            begin
                at(200);
                in_v[0] = 1'b1;
            end
            for (int w = 0; w < 5; w++) begin
                wait_valid(0, 105, ok);
                e = exp_q.pop_front();
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL hold_timeout w%0d: no valid in 105 cycles", w);
                end else if ({o[0], f[0]} !== e) begin
                    errors++;
                    $display("FAIL hold w%0d: got ovf=%0b freq=%h, want ovf=%0b freq=%h", w, o[0], f[0], e[16], e[15:0]);
                end
                if (w > 0) begin
                    checks++;
                    if (cyc - last !== 100) begin
                        errors++;
                        $display("FAIL hold_interval w%0d: got %0d, want 100", w, cyc - last);
                    end
                end
                last = cyc;
            end
        join
        in_v[0] = 1'b0;
    endtask

    task automatic test_terminal;
        do_reset;
        exp_q.push_back(17'h0_0005);
        exp_q.push_back(17'h0_0000);
        fork
            begin
                pulses(0, 4, 5);
                at(97);
                in_v[0] = 1'b1;
            end
            for (int w = 0; w < 2; w++) begin
                wait_valid(0, 105, ok);
                e = exp_q.pop_front();
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL terminal_timeout w%0d: no valid in 105 cycles", w);
                end else if ({o[0], f[0]} !== e) begin
                    errors++;
                    $display("FAIL terminal w%0d: got ovf=%0b freq=%h, want ovf=%0b freq=%h", w, o[0], f[0], e[16], e[15:0]);
                end
            end
        join
        in_v[0] = 1'b0;
    endtask

    task automatic test_bcd;
        do_reset;
        exp_q.push_back(17'h0_1234);
        exp_q.push_back(17'h0_1000);
        bad = 0;
        fork
            begin
                pulses(1, 1234, 2);
                at(5000);
                pulses(1, 1000, 2);
            end
            for (int w = 0; w < 2; w++) begin
                wait_valid(1, 5005, ok);
                e = exp_q.pop_front();
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL bcd_timeout w%0d: no valid in 5005 cycles", w);
                end else if ({o[1], f[1]} !== e) begin
                    errors++;
                    $display("FAIL bcd w%0d: got ovf=%0b freq=%h, want ovf=%0b freq=%h", w, o[1], f[1], e[16], e[15:0]);
                end
            end
            for (int k = 0; k < 10001; k++) begin
                tick;
                if (has_af(f[1])) bad++;
            end
        join
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bcd_digits: got %0d cycles with A-F nibbles, want 0", bad);
        end
    endtask

    task automatic test_sat;
        do_reset;
        exp_q.push_back({1'b1, 16'h9999});
        exp_q.push_back({1'b0, 16'h0003});
        fork
            begin
                pulses(2, 12499, 1);
                at(25010);
                pulses(2, 3, 2);
            end
            for (int w = 0; w < 2; w++) begin
                wait_valid(2, 25005, ok);
                e = exp_q.pop_front();
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL sat_timeout w%0d: no valid in 25005 cycles", w);
                end else if ({o[2], f[2]} !== e) begin
                    errors++;
                    $display("FAIL sat w%0d: got ovf=%0b freq=%h, want ovf=%0b freq=%h", w, o[2], f[2], e[16], e[15:0]);
                end
            end
        join
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_period10;
        test_reset_mid;
        test_hold;
        test_terminal;
        test_bcd;
        test_sat;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
